// File: rtl/booth_pkg.sv
// Shared types and helpers for the sequential radix-2 Booth multiplier.
package booth_pkg;

  typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_e;

  typedef enum logic [1:0] {OP_NOP = 2'd0, OP_ADD = 2'd1, OP_SUB = 2'd2} booth_op_e;

  // cnt must hold 0..WIDTH
  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

  function automatic booth_op_e booth_decode(input logic q0, input logic q_m1);
    case ({q0, q_m1})
      2'b10:   return OP_SUB;
      2'b01:   return OP_ADD;
      default: return OP_NOP;
    endcase
  endfunction

endpackage

// File: rtl/booth_mul_seq_if.sv
// Start/done handshake and operand/result bus of the Booth multiplier.
interface booth_mul_seq_if #(parameter int WIDTH = 16);
  logic                 start;
  logic                 is_signed;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   p;

  modport master (output start, is_signed, a, b, input busy, done, p);
  modport slave  (input start, is_signed, a, b, output busy, done, p);
endinterface

// File: rtl/booth_radix2_step.sv
// One combinational radix-2 Booth step: add/sub selected by {q[0],q_m1}, then arithmetic shift right.
module booth_radix2_step
  import booth_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic signed [WIDTH:0] acc,
  input  logic        [WIDTH:0] q,
  input  logic                  q_m1,
  input  logic signed [WIDTH:0] m,
  output logic signed [WIDTH:0] acc_nxt,
  output logic        [WIDTH:0] q_nxt,
  output logic                  q_m1_nxt
);

  logic signed [WIDTH:0] sum;

  always_comb begin
    sum = acc;
    case (booth_decode(q[0], q_m1))
      OP_ADD:  sum = acc + m;
      OP_SUB:  sum = acc - m;
      default: sum = acc;
    endcase
    // shift {sum,q,q_m1} right by one, sign from the post-add accumulator
    acc_nxt  = sum >>> 1;
    q_nxt    = {sum[0], q[WIDTH:1]};
    q_m1_nxt = q[0];
  end

endmodule

// File: rtl/booth_mul_seq.sv
// Iterative radix-2 Booth multiplier: WIDTH+1 add/sub/shift steps on (WIDTH+1)-bit extended operands.
module booth_mul_seq
  import booth_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic           clk,
  input  logic           rst,
  booth_mul_seq_if.slave bus
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [0:0] S_IDLE = IDLE;
  localparam logic [0:0] S_RUN  = RUN;

  logic [0:0]            state;
  logic signed [WIDTH:0] acc;
  logic        [WIDTH:0] q;
  logic                  q_m1;
  logic signed [WIDTH:0] m;
  logic [CW-1:0]         cnt;

  logic signed [WIDTH:0] acc_n;
  logic        [WIDTH:0] q_n;
  logic                  q_m1_n;
  logic signed [WIDTH:0] a_ext;
  logic        [WIDTH:0] b_ext;

  // one extra bit makes unsigned operands exact in the signed Booth recoding
  assign a_ext = {bus.is_signed & bus.a[WIDTH-1], bus.a};
  assign b_ext = {bus.is_signed & bus.b[WIDTH-1], bus.b};

  booth_radix2_step #(.WIDTH(WIDTH)) u_step (
    .acc      (acc),
    .q        (q),
    .q_m1     (q_m1),
    .m        (m),
    .acc_nxt  (acc_n),
    .q_nxt    (q_n),
    .q_m1_nxt (q_m1_n)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      acc      <= '0;
      q        <= '0;
      q_m1     <= 1'b0;
      m        <= '0;
      cnt      <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.p    <= '0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            acc      <= '0;
            q        <= b_ext;
            q_m1     <= 1'b0;
            m        <= a_ext;
            cnt      <= '0;
            bus.busy <= 1'b1;
            state    <= S_RUN;
          end
        end
        default: begin
          acc  <= acc_n;
          q    <= q_n;
          q_m1 <= q_m1_n;
          cnt  <= cnt + 1'b1;
          if (cnt == CW'(WIDTH)) begin
            // low 2*WIDTH bits of the post-shift {acc,q}
            bus.p    <= {acc_n[WIDTH-2:0], q_n};
            bus.done <= 1'b1;
            bus.busy <= 1'b0;
            state    <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule
